// File: rtl/sram_pkg.sv
// Shared types, constants and helpers for the byte-enable dual-port SRAM.
// Combinational only; no timing and no backpressure.
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Write/read port bundle for sram_dp_be: master issues requests, slave returns read data.
// Latency and backpressure are set by the attached slave; init_busy blocks both ports.
interface sram_dp_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    import sram_pkg::*;

    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                  init_busy;
    logic                  wr_cs_n;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_BYTES-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_cs_n;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        input  init_busy, rd_data, rd_valid,
        output wr_cs_n, wr_en, wr_addr, wr_be, wr_data,
        output rd_cs_n, rd_en, rd_addr
    );

    modport slave (
        output init_busy, rd_data, rd_valid,
        input  wr_cs_n, wr_en, wr_addr, wr_be, wr_data,
        input  rd_cs_n, rd_en, rd_addr
    );

endinterface

// File: rtl/sram_init_ctrl.sv
// INIT/READY controller: sweeps addresses 0..DATA_DEPTH-1 once after reset, one word per cycle.
// init_busy is registered state; busy for exactly DATA_DEPTH cycles, no backpressure input.
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy_o,
    output logic [ADDR_WIDTH-1:0] sweep_addr_o,
    output logic                  sweep_we_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_we_o = 1'b0;
        if (state_q == INIT) begin
            sweep_we_o = 1'b1;
            // Leave INIT at the same edge that writes the last word.
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign init_busy_o  = (state_q == INIT);
    assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane writes, post-reset init sweep and selectable read-during-write.
// Latency: writes land at the accepting edge, reads RD_LATENCY (1|2) cycles; no backpressure, ports blocked while init_busy.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_DEPTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    sram_dp_be_if.slave bus
);

    localparam int                  NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int                  IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic                  init_busy;
    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_init_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_busy_o  (init_busy),
        .sweep_addr_o (sweep_addr),
        .sweep_we_o   (sweep_we)
    );

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic wr_acc, rd_acc, wr_in_rng, rd_in_rng, rdw_hit;

    assign wr_acc    = !init_busy && !bus.wr_cs_n && bus.wr_en;
    assign rd_acc    = !init_busy && !bus.rd_cs_n && bus.rd_en;
    assign wr_in_rng = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign rd_in_rng = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign rdw_hit   = wr_acc && wr_in_rng && (bus.wr_addr == bus.rd_addr);

    // The sweep owns the write port while busy; user writes are already gated off then.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [NUM_BYTES-1:0]  mem_be;
    logic [DATA_WIDTH-1:0] mem_wdat;

    always_comb begin
        mem_we    = wr_acc && wr_in_rng;
        mem_waddr = bus.wr_addr;
        mem_be    = bus.wr_be;
        mem_wdat  = bus.wr_data;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_be    = '1;
            mem_wdat  = INIT_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_we && mem_be[i]) begin
                mem_q[mem_waddr[IDX_W-1:0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_old, rd_merged, rd_word_d;

    always_comb begin
        rd_old    = rd_in_rng ? mem_q[bus.rd_addr[IDX_W-1:0]] : '0;
        rd_merged = rd_old;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.wr_be[i]) begin
                rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word_d = (RDW_MODE == RDW_NEW && rdw_hit) ? rd_merged : rd_old;
    end

    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] s1_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
                s1_dat_q <= rd_word_d;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  out_vld_q;
            logic [DATA_WIDTH-1:0] out_dat_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_vld_q <= 1'b0;
                    out_dat_q <= '0;
                end else begin
                    out_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        out_dat_q <= s1_dat_q;
                    end
                end
            end

            assign bus.rd_valid = out_vld_q;
            assign bus.rd_data  = out_dat_q;
        end else begin : g_lat1
            assign bus.rd_valid = s1_vld_q;
            assign bus.rd_data  = s1_dat_q;
        end
    endgenerate

    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_sram_dp_be.sv
// Randomised and directed bench for two sram_dp_be configurations against a word-level reference model.
// Instance A: 16x32, latency 1, old-data RDW, INIT A5A5A5A5. Instance B: 20x32 (5-bit addr), latency 2, new-data RDW, INIT 0.
module tb_sram_dp_be;
    import sram_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_dp_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) ifa ();
    sram_dp_be_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8)) ifb ();

    sram_dp_be #(
        .ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .RD_LATENCY(1), .RDW_MODE(RDW_OLD), .INIT_VALUE(32'hA5A5A5A5)
    ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    sram_dp_be #(
        .ADDR_WIDTH(5), .DATA_DEPTH(20), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .RD_LATENCY(2), .RDW_MODE(RDW_NEW), .INIT_VALUE(32'h0)
    ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int          DEP   [2] = '{16, 20};
    int          LAT   [2] = '{1, 2};
    bit          RDWN  [2] = '{1'b0, 1'b1};
    logic [31:0] INITV [2] = '{32'hA5A5A5A5, 32'h0};

    logic        obs_busy [2];
    logic        obs_vld  [2];
    logic [31:0] obs_dat  [2];
    assign obs_busy[0] = ifa.init_busy;
    assign obs_busy[1] = ifb.init_busy;
    assign obs_vld[0]  = ifa.rd_valid;
    assign obs_vld[1]  = ifb.rd_valid;
    assign obs_dat[0]  = ifa.rd_data;
    assign obs_dat[1]  = ifb.rd_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next-cycle stimulus per instance
    bit          s_wcs_n [2];
    bit          s_wen   [2];
    int          s_wa    [2];
    logic [3:0]  s_be    [2];
    logic [31:0] s_wd    [2];
    bit          s_rcs_n [2];
    bit          s_ren   [2];
    int          s_ra    [2];

    // Reference model: contents, outstanding read results by due slot, last returned word
    logic [31:0] mem_m    [2][32];
    bit          ev       [2][4];
    logic [31:0] ed       [2][4];
    logic [31:0] last_dat [2];
    int          npos     [2];
    int          tcur = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            s_wcs_n[i] = 1'b1; s_wen[i] = 1'b0; s_wa[i] = 0; s_be[i] = 4'h0; s_wd[i] = 32'h0;
            s_rcs_n[i] = 1'b1; s_ren[i] = 1'b0; s_ra[i] = 0;
        end
    endtask

    task automatic set_wr(input int i, input int a, input logic [3:0] be, input logic [31:0] d);
        s_wcs_n[i] = 1'b0; s_wen[i] = 1'b1; s_wa[i] = a; s_be[i] = be; s_wd[i] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        s_rcs_n[i] = 1'b0; s_ren[i] = 1'b1; s_ra[i] = a;
    endtask

    task automatic rand_stim(input int i);
        int amax;
        amax = (i == 0) ? 15 : 31;
        s_wcs_n[i] = ($urandom_range(0, 9) < 2);
        s_wen[i]   = ($urandom_range(0, 9) < 7);
        s_wa[i]    = int'($urandom_range(0, amax));
        s_be[i]    = 4'($urandom);
        s_wd[i]    = $urandom;
        s_rcs_n[i] = ($urandom_range(0, 9) < 2);
        s_ren[i]   = ($urandom_range(0, 9) < 7);
        s_ra[i]    = ($urandom_range(0, 2) == 0) ? s_wa[i] : int'($urandom_range(0, amax));
    endtask

    task automatic drive();
        ifa.wr_cs_n = s_wcs_n[0]; ifa.wr_en = s_wen[0]; ifa.wr_addr = 4'(s_wa[0]);
        ifa.wr_be   = s_be[0];    ifa.wr_data = s_wd[0];
        ifa.rd_cs_n = s_rcs_n[0]; ifa.rd_en = s_ren[0]; ifa.rd_addr = 4'(s_ra[0]);
        ifb.wr_cs_n = s_wcs_n[1]; ifb.wr_en = s_wen[1]; ifb.wr_addr = 5'(s_wa[1]);
        ifb.wr_be   = s_be[1];    ifb.wr_data = s_wd[1];
        ifb.rd_cs_n = s_rcs_n[1]; ifb.rd_en = s_ren[1]; ifb.rd_addr = 5'(s_ra[1]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            npos[i]     = 0;
            last_dat[i] = 32'h0;
            for (int s = 0; s < 4; s++) ev[i][s] = 1'b0;
            // Words written during the sweep are dropped, so afterwards everything holds INIT.
            for (int a = 0; a < 32; a++) mem_m[i][a] = INITV[i];
        end
    endtask

    // Sample at the falling edge, then apply the pending stimulus for the next rising edge.
    task automatic cycle();
        @(negedge clk);
        tcur++;
        for (int i = 0; i < 2; i++) begin
            int          sl;
            bit          busy, wacc, racc;
            logic [31:0] v;
            npos[i]++;
            sl = tcur % 4;
            check($sformatf("busy[%0d]", i), 32'(obs_busy[i]), 32'(npos[i] < DEP[i]));
            if (ev[i][sl]) last_dat[i] = ed[i][sl];
            check($sformatf("rd_valid[%0d]", i), 32'(obs_vld[i]), 32'(ev[i][sl]));
            check($sformatf("rd_data[%0d]", i), obs_dat[i], last_dat[i]);
            ev[i][sl] = 1'b0;

            busy = (npos[i] < DEP[i]);
            wacc = !busy && !s_wcs_n[i] && s_wen[i];
            racc = !busy && !s_rcs_n[i] && s_ren[i];
            if (racc) begin
                if (s_ra[i] >= DEP[i]) begin
                    v = 32'h0;
                end else begin
                    v = mem_m[i][s_ra[i]];
                    if (RDWN[i] && wacc && s_wa[i] == s_ra[i]) v = merge(v, s_wd[i], s_be[i]);
                end
                ev[i][(tcur + LAT[i]) % 4] = 1'b1;
                ed[i][(tcur + LAT[i]) % 4] = v;
            end
            if (wacc && s_wa[i] < DEP[i]) mem_m[i][s_wa[i]] = merge(mem_m[i][s_wa[i]], s_wd[i], s_be[i]);
        end
        drive();
    endtask

    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid[%0d]", i), 32'(obs_vld[i]), 32'h0);
            check($sformatf("rst_data[%0d]", i), obs_dat[i], 32'h0);
            check($sformatf("rst_busy[%0d]", i), 32'(obs_busy[i]), 32'h1);
        end
        idle();
        drive();
        model_reset();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        drive();
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("por_busy[%0d]", i), 32'(obs_busy[i]), 32'h1);
            check($sformatf("por_valid[%0d]", i), 32'(obs_vld[i]), 32'h0);
            check($sformatf("por_data[%0d]", i), obs_dat[i], 32'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Abort the sweep in its 7th cycle; the restarted sweep must run its full length.
        repeat (6) cycle();
        do_reset(2);

        // Traffic during the sweep must be ignored.
        for (int k = 0; k < 15; k++) begin
            rand_stim(0);
            rand_stim(1);
            cycle();
        end
        idle();
        repeat (6) cycle();

        for (int a = 0; a < 20; a++) begin
            idle();
            set_rd(0, a % 16);
            set_rd(1, a);
            cycle();
        end
        idle();
        repeat (3) cycle();
        check("init_word_a", obs_dat[0], 32'hA5A5A5A5);

        // Byte-lane merge on A
        idle(); set_wr(0, 3, 4'hF, 32'h11223344); cycle();
        idle(); set_wr(0, 3, 4'b0101, 32'hAABBCCDD); cycle();
        idle(); set_rd(0, 3); cycle();
        idle(); cycle();
        check("be_merge", obs_dat[0], 32'h11BB33DD);

        // Same-address read during write
        idle(); set_wr(0, 5, 4'hF, 32'h0); cycle();
        idle();
        set_wr(0, 5, 4'hF, 32'hDEADBEEF); set_rd(0, 5);
        set_wr(1, 5, 4'hF, 32'hDEADBEEF); set_rd(1, 5);
        cycle();
        idle(); cycle();
        check("rdw_old", obs_dat[0], 32'h0);
        cycle();
        check("rdw_new", obs_dat[1], 32'hDEADBEEF);

        // Latency-2 back-to-back reads on B
        idle(); set_wr(1, 0, 4'hF, 32'h10); cycle();
        idle(); set_wr(1, 1, 4'hF, 32'h20); cycle();
        idle(); set_wr(1, 2, 4'hF, 32'h30); cycle();
        idle(); set_rd(1, 0); cycle();
        idle(); set_rd(1, 1); cycle();
        check("lat2_v0", 32'(obs_vld[1]), 32'h0);
        idle(); set_rd(1, 2); cycle();
        check("lat2_v1", 32'(obs_vld[1]), 32'h1);
        check("lat2_d1", obs_dat[1], 32'h10);
        idle(); cycle();
        check("lat2_v2", 32'(obs_vld[1]), 32'h1);
        check("lat2_d2", obs_dat[1], 32'h20);
        cycle();
        check("lat2_v3", 32'(obs_vld[1]), 32'h1);
        check("lat2_d3", obs_dat[1], 32'h30);
        cycle();
        check("lat2_v4", 32'(obs_vld[1]), 32'h0);
        check("lat2_hold", obs_dat[1], 32'h30);

        // Out-of-range on B: write dropped, read returns zero with a valid
        idle(); set_wr(1, 25, 4'hF, 32'h12345678); set_rd(1, 25); cycle();
        idle(); cycle();
        cycle();
        check("oor_valid", 32'(obs_vld[1]), 32'h1);
        check("oor_data", obs_dat[1], 32'h0);
        for (int a = 0; a < 20; a++) begin
            idle(); set_rd(1, a); cycle();
        end

        repeat (300) begin
            rand_stim(0);
            rand_stim(1);
            cycle();
        end

        // Reset with reads in flight
        idle(); set_rd(0, 1); set_rd(1, 1); cycle();
        idle(); set_rd(0, 2); set_rd(1, 2); cycle();
        do_reset(2);

        repeat (260) begin
            rand_stim(0);
            rand_stim(1);
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised simple-dual-port SRAM with independent write and read ports, per-byte write enables, selectable read latency and read-during-write mode. Memory is cleared by a post-reset initialisation sweep, not an asynchronous array reset. It is the next-generation storage block for the chapter projects, a drop-in for buffers and register files that need concurrent read and write.

## Interface

- ADDR_WIDTH, 4: address bits on both ports
- DATA_DEPTH, 16: number of words; must be ≤ 2^ADDR_WIDTH
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8: bits per byte lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
- RD_LATENCY, 1: read latency in cycles; legal values are 1 and 2
- RDW_MODE, 0: same-address read-during-write behaviour; 0 = return old data, 1 = return new (merged) data
- INIT_VALUE, 0: value written to every word by the init sweep

- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- init_busy  out  1  high while the init sweep runs; both ports are blocked
- wr_cs_n  in  1  write-port chip select, active-low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_be  in  NUM_BYTES  byte-lane enables; bit i selects lane i
- wr_data  in  DATA_WIDTH  write data
- rd_cs_n  in  1  read-port chip select, active-low
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data; holds its last value when no read completes
- rd_valid  out  1  one-cycle pulse marking rd_data as carrying a completed read

## Operation

- The controller has two states, INIT and READY.
- Reset drives state to INIT, the sweep counter to 0, init_busy to 1, rd_data to 0, rd_valid to 0, and flushes the read pipeline.
- In INIT, one word per cycle is written with INIT_VALUE, at addresses 0 through DATA_DEPTH-1. After the write to DATA_DEPTH-1, state goes to READY and init_busy goes to 0 on the next edge.
- While init_busy = 1, user writes are dropped and user reads are not accepted (no rd_valid).
- A write is accepted when wr_cs_n = 0, wr_en = 1 and init_busy = 0. Only lanes with wr_be[i] = 1 are updated. wr_be = 0 makes no change.
- A read is accepted when rd_cs_n = 0, rd_en = 1 and init_busy = 0.
- Out-of-range address (≥ DATA_DEPTH): the write is ignored; the read completes normally with rd_data = 0 and rd_valid = 1.
- Same-address accepted write and read in the same cycle:
  - RDW_MODE = 0: the read returns the pre-write word.
  - RDW_MODE = 1: the read returns the merged word (enabled lanes take new data, other lanes keep old data).
- Different addresses do not interact.
- Reset mid-operation aborts the sweep or any in-flight read; no rd_valid is issued for reads accepted before reset. The array contents are not guaranteed until the next sweep finishes.

## Timing

- Write: the array is updated at the accepting edge; a read accepted in the next cycle sees the new data.
- RD_LATENCY = 1: rd_data and rd_valid update at the edge that accepts the read, i.e. they are visible in the cycle after the request.
- RD_LATENCY = 2: an additional output register is added; data and valid appear one cycle later. Back-to-back reads are supported at one per cycle with either latency.
- The init sweep lasts exactly DATA_DEPTH cycles after rst_n deasserts. The first read can be accepted in cycle DATA_DEPTH+1.
- Outputs are driven from registers only; there is no combinational path from inputs to outputs.

## Structure

- Package sram_pkg holds:
  - the state enum (INIT, READY)
  - constants RDW_OLD = 0 and RDW_NEW = 1
  - function num_bytes(DATA_WIDTH, BYTE_WIDTH)
- Sub-module sram_init_ctrl contains the INIT/READY FSM and the sweep counter. It outputs init_busy, the sweep address and the sweep write enable.
- The top level muxes sweep writes against user writes, and holds the array, the byte-lane merge and the read pipeline.

## Test plan

- Reset, then idle: init_busy = 1 for 16 cycles after rst_n rises. With INIT_VALUE = 0xA5A5A5A5, reading addresses 0–15 returns 0xA5A5A5A5 each time with one rd_valid per read.
- Write 0x11223344 to address 3, then write wr_be = 4'b0101 with data 0xAABBCCDD to address 3, then read address 3 → 0x11BB33DD.
- Same-cycle write 0xDEADBEEF (wr_be = 4'hF) and read of address 5, which holds 0: RDW_MODE = 0 returns 0x00000000; RDW_MODE = 1 returns 0xDEADBEEF.
- RD_LATENCY = 2, back-to-back reads of addresses 0, 1, 2 holding 0x10, 0x20, 0x30 → rd_valid high for 3 consecutive cycles starting 2 cycles after the first request, data 0x10, 0x20, 0x30.
- Write and read attempts during init_busy: no array change after the sweep, no rd_valid. With ADDR_WIDTH = 5 and DATA_DEPTH = 20, a read of address 25 → rd_data = 0, rd_valid = 1; a write to address 25 has no effect.
- Assert rst_n low in cycle 7 of the sweep and mid-read: rd_data = 0 and rd_valid = 0 immediately, and the sweep restarts with a full 16-cycle init_busy.
